// File: rtl/video_blitter_seq.sv
// Picture-ROM to video-RAM rectangle blitter: CPU-programmed source/destination/size,
// one ROM word fetched and written per pixel, with plane masking and transparency skip.
module video_blitter_seq #(
   parameter int ROM_WAIT   = 1,
   parameter int DST_STRIDE = 256,
   parameter int VA_W       = 14
) (
   input  logic            CLK,
   input  logic            MR_AL,
   input  logic            REG_WR,
   input  logic [2:0]      REG_SEL,
   input  logic [7:0]      REG_DIN,
   output logic            BUSY,
   output logic            DONE,
   output logic [12:0]     ABP,
   input  logic [15:0]     DP,
   output logic [VA_W-1:0] VA,
   output logic [15:0]     VD,
   output logic            VWE_AL,
   input  logic            VRDY
);

   typedef enum logic [1:0] {IDLE, FETCH, WRITE, ADV} state_t;

   localparam logic [1:0]      WAIT_LAST = 2'(ROM_WAIT - 1);
   localparam logic [VA_W-1:0] STRIDE    = VA_W'(DST_STRIDE);

   state_t state, state_nx;

   logic [7:0]      src_l, dst_l, width, height;
   logic [4:0]      src_h;
   logic [5:0]      dst_h;
   logic            transp;
   logic [3:0]      planes;

   logic [7:0]      col, row;
   logic [1:0]      wait_cnt;
   logic [VA_W-1:0] row_start;
   logic [VA_W-1:0] dst_addr;
   logic [15:0]     masked_dp;
   logic            reg_wr_ok, start_req, fetch_done, col_last, last_px;

   // Registers are only writable while idle; a running copy never sees a change.
   assign reg_wr_ok  = REG_WR && (state == IDLE);
   assign start_req  = reg_wr_ok && (REG_SEL == 3'd6) && REG_DIN[0];
   assign fetch_done = (state == FETCH) && (wait_cnt == WAIT_LAST);
   assign col_last   = (col == width);
   assign last_px    = col_last && (row == height);
   assign dst_addr   = VA_W'({dst_h, dst_l});

   assign BUSY   = (state != IDLE);
   assign VWE_AL = (state != WRITE);

   // planes[i] gates nibble i: {Z,R,G,B} = planes[3:0]
   for (genvar i = 0; i < 4; i++) begin : g_mask
      assign masked_dp[4*i +: 4] = planes[i] ? DP[4*i +: 4] : 4'h0;
   end

   always_ff @(posedge CLK or negedge MR_AL) begin
      if (!MR_AL) begin
         src_l  <= '0;
         src_h  <= '0;
         dst_l  <= '0;
         dst_h  <= '0;
         width  <= '0;
         height <= '0;
         transp <= 1'b0;
         planes <= '0;
      end else if (reg_wr_ok) begin
         case (REG_SEL)
            3'd0: src_l  <= REG_DIN;
            3'd1: src_h  <= REG_DIN[4:0];
            3'd2: dst_l  <= REG_DIN;
            3'd3: dst_h  <= REG_DIN[5:0];
            3'd4: width  <= REG_DIN;
            3'd5: height <= REG_DIN;
            3'd6: begin
               transp <= REG_DIN[1];
               planes <= REG_DIN[5:2];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge MR_AL) begin
      if (!MR_AL) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start_req) state_nx = FETCH;
         FETCH: if (fetch_done) state_nx = (transp && masked_dp == 16'h0) ? ADV : WRITE;
         WRITE: if (VRDY) state_nx = ADV;
         ADV:   state_nx = last_px ? IDLE : FETCH;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge MR_AL) begin
      if (!MR_AL) begin
         ABP       <= '0;
         VA        <= '0;
         VD        <= '0;
         DONE      <= 1'b0;
         row_start <= '0;
         col       <= '0;
         row       <= '0;
         wait_cnt  <= '0;
      end else begin
         DONE <= (state == ADV) && last_px;
         case (state)
            IDLE: if (start_req) begin
               ABP       <= {src_h, src_l};
               VA        <= dst_addr;
               row_start <= dst_addr;
               col       <= '0;
               row       <= '0;
               wait_cnt  <= '0;
            end
            FETCH: begin
               wait_cnt <= wait_cnt + 2'd1;
               if (fetch_done) VD <= masked_dp;
            end
            ADV: begin
               ABP      <= ABP + 13'd1;
               wait_cnt <= '0;
               if (!col_last) begin
                  col <= col + 8'd1;
                  VA  <= VA + VA_W'(1);
               end else begin
                  // next row restarts from the previous row origin, not from VA
                  col       <= '0;
                  row       <= row + 8'd1;
                  VA        <= row_start + STRIDE;
                  row_start <= row_start + STRIDE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_video_blitter_seq.sv
// Directed bench for video_blitter_seq: a write scoreboard fed by a per-copy reference
// model, checked on every completed video RAM write.
module tb_video_blitter_seq;
   localparam int VA_W = 14;

   logic            CLK = 1'b0;
   logic            MR_AL = 1'b0;
   logic            REG_WR = 1'b0;
   logic [2:0]      REG_SEL = '0;
   logic [7:0]      REG_DIN = '0;
   logic            BUSY, DONE, VWE_AL;
   logic [12:0]     ABP;
   logic [15:0]     DP, VD;
   logic [VA_W-1:0] VA;
   logic            VRDY = 1'b1;

   logic [15:0] rom [0:8191];
   assign DP = rom[ABP];

   video_blitter_seq #(.ROM_WAIT(1), .DST_STRIDE(256), .VA_W(VA_W)) dut (
      .CLK(CLK), .MR_AL(MR_AL), .REG_WR(REG_WR), .REG_SEL(REG_SEL), .REG_DIN(REG_DIN),
      .BUSY(BUSY), .DONE(DONE), .ABP(ABP), .DP(DP), .VA(VA), .VD(VD),
      .VWE_AL(VWE_AL), .VRDY(VRDY)
   );

   always #5 CLK = ~CLK;

   int total = 0, passed = 0;
   int busy_cnt = 0, done_cnt = 0, wr_cnt = 0;
   int d0, w0;
   logic [29:0] sb [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Called at a falling edge; samples just before the next rising edge, then realigns.
   task automatic tick();
      logic [29:0] e;
      #4;
      if (BUSY) busy_cnt++;
      if (DONE) done_cnt++;
      if (!VWE_AL && VRDY) begin
         wr_cnt++;
         chk("write_expected", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("write_va_vd", {2'b0, VA, VD}, {2'b0, e});
         end
      end
      @(negedge CLK);
   endtask

   task automatic wr_reg(input logic [2:0] sel, input logic [7:0] din);
      REG_SEL = sel; REG_DIN = din; REG_WR = 1'b1;
      tick();
      REG_WR = 1'b0;
   endtask

   task automatic setup(input logic [12:0] src, input logic [13:0] dst,
                        input logic [7:0] w, input logic [7:0] h);
      wr_reg(3'd0, src[7:0]);
      wr_reg(3'd1, {3'b0, src[12:8]});
      wr_reg(3'd2, dst[7:0]);
      wr_reg(3'd3, {2'b0, dst[13:8]});
      wr_reg(3'd4, w);
      wr_reg(3'd5, h);
   endtask

   task automatic start(input logic [3:0] planes, input logic transp);
      wr_reg(3'd6, {2'b0, planes, transp, 1'b1});
   endtask

   task automatic push_model(input logic [12:0] src, input logic [13:0] dst, input int w,
                             input int h, input logic [3:0] planes, input logic transp);
      logic [15:0] mask, vd;
      logic [12:0] a;
      logic [13:0] va;
      mask = {{4{planes[3]}}, {4{planes[2]}}, {4{planes[1]}}, {4{planes[0]}}};
      for (int r = 0; r <= h; r++)
         for (int c = 0; c <= w; c++) begin
            a  = 13'(int'(src) + r * (w + 1) + c);
            va = 14'(int'(dst) + r * 256 + c);
            vd = rom[a] & mask;
            if (!(transp && vd == 16'h0)) sb.push_back({va, vd});
         end
   endtask

   task automatic wait_vwe(input int budget);
      int n = 0;
      while (VWE_AL && n < budget) begin tick(); n++; end
      chk("vwe_reached", 32'(VWE_AL), 0);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      int base = done_cnt;
      while (done_cnt == base && n < budget) begin tick(); n++; end
      chk("done_seen", 32'(done_cnt != base), 1);
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) rom[i] = 16'(i * 40503 + 4660) | 16'h0001;
      rom[13'h201] = 16'h0000;
      rom[13'h300] = 16'hABCD;

      @(negedge CLK);
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_done", 32'(DONE), 0);
      chk("rst_abp", 32'(ABP), 0);
      chk("rst_va", 32'(VA), 0);
      chk("rst_vd", 32'(VD), 0);
      chk("rst_vwe", 32'(VWE_AL), 1);
      MR_AL = 1'b1;
      repeat (2) tick();

      // 2x2 copy, full throughput
      setup(13'h0100, 14'h0010, 8'd1, 8'd1);
      push_model(13'h0100, 14'h0010, 1, 1, 4'hF, 1'b0);
      busy_cnt = 0; d0 = done_cnt; w0 = wr_cnt;
      start(4'hF, 1'b0);
      wait_done(100);
      repeat (3) tick();
      chk("2x2_done_once", done_cnt - d0, 1);
      chk("2x2_busy_cycles", busy_cnt, 12);
      chk("2x2_writes", wr_cnt - w0, 4);
      chk("2x2_sb_empty", sb.size(), 0);

      // VRDY stall on the first write
      VRDY = 1'b0;
      setup(13'h0140, 14'h0200, 8'd1, 8'd0);
      push_model(13'h0140, 14'h0200, 1, 0, 4'hF, 1'b0);
      w0 = wr_cnt;
      start(4'hF, 1'b0);
      wait_vwe(20);
      for (int k = 0; k < 5; k++) begin
         chk("stall_vwe", 32'(VWE_AL), 0);
         chk("stall_va", 32'(VA), 32'(sb[0][29:16]));
         chk("stall_vd", 32'(VD), 32'(sb[0][15:0]));
         tick();
      end
      VRDY = 1'b1;
      wait_done(100);
      repeat (2) tick();
      chk("stall_writes", wr_cnt - w0, 2);
      chk("stall_sb_empty", sb.size(), 0);

      // Transparency: pixel 1 is zero and skipped, later pixels keep their positions
      setup(13'h0200, 14'h0300, 8'd3, 8'd0);
      push_model(13'h0200, 14'h0300, 3, 0, 4'hF, 1'b1);
      chk("transp_expected_cnt", sb.size(), 3);
      busy_cnt = 0; w0 = wr_cnt;
      start(4'hF, 1'b1);
      wait_done(100);
      repeat (2) tick();
      chk("transp_writes", wr_cnt - w0, 3);
      chk("transp_busy_cycles", busy_cnt, 11);
      chk("transp_sb_empty", sb.size(), 0);

      // Plane mask: R only
      setup(13'h0300, 14'h0400, 8'd0, 8'd0);
      sb.push_back({14'h0400, 16'h0B00});
      w0 = wr_cnt;
      start(4'b0100, 1'b0);
      wait_done(50);
      repeat (2) tick();
      chk("plane_writes", wr_cnt - w0, 1);
      chk("plane_sb_empty", sb.size(), 0);

      // Address wrap on both ROM and video RAM
      setup(13'h1FFF, 14'h3FFF, 8'd1, 8'd0);
      sb.push_back({14'h3FFF, rom[13'h1FFF]});
      sb.push_back({14'h0000, rom[13'h0000]});
      w0 = wr_cnt;
      start(4'hF, 1'b0);
      wait_done(50);
      repeat (2) tick();
      chk("wrap_writes", wr_cnt - w0, 2);
      chk("wrap_sb_empty", sb.size(), 0);

      // Register writes ignored while busy
      setup(13'h0500, 14'h0040, 8'd3, 8'd0);
      push_model(13'h0500, 14'h0040, 3, 0, 4'hF, 1'b0);
      w0 = wr_cnt;
      start(4'hF, 1'b0);
      wait_vwe(20);
      wr_reg(3'd2, 8'h99);
      wait_done(100);
      repeat (2) tick();
      chk("lock_sb_empty1", sb.size(), 0);
      push_model(13'h0500, 14'h0040, 3, 0, 4'hF, 1'b0);
      start(4'hF, 1'b0);
      wait_done(100);
      repeat (2) tick();
      chk("lock_sb_empty2", sb.size(), 0);
      chk("lock_writes", wr_cnt - w0, 8);

      // Async reset in the middle of a stalled write
      VRDY = 1'b0;
      setup(13'h0600, 14'h0500, 8'd1, 8'd1);
      start(4'hF, 1'b0);
      wait_vwe(20);
      MR_AL = 1'b0;
      #1;
      chk("abort_vwe", 32'(VWE_AL), 1);
      chk("abort_busy", 32'(BUSY), 0);
      chk("abort_done", 32'(DONE), 0);
      chk("abort_va", 32'(VA), 0);
      chk("abort_abp", 32'(ABP), 0);
      @(negedge CLK);
      VRDY = 1'b1;
      MR_AL = 1'b1;
      d0 = done_cnt; w0 = wr_cnt;
      repeat (20) tick();
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_no_write", wr_cnt - w0, 0);
      chk("abort_idle", 32'(BUSY), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/video_blitter_seq.md
Name: video_blitter_seq

Overview:
Picture-ROM blitter sequencer for the video board. It sits directly upstream of the picture ROM: it drives ABP[12:0], samples the returned 16-bit DP word {DPZ,DPR,DPG,DPB}, and writes that word as one pixel-group into video RAM. The CPU programs a source address, destination address, width, height and mode through a small register file, then starts a rectangular copy. The block runs until the copy completes.

Parameters:
ROM_WAIT, 1, cycles from ABP change to DP valid (1..3)
DST_STRIDE, 256, video RAM words per display row
VA_W, 14, video RAM address width

Ports:
CLK  in  1  system clock, rising edge
MR_AL  in  1  master reset, asynchronous, active-low
REG_WR  in  1  CPU register write strobe, one CLK wide
REG_SEL  in  3  register index 0..6
REG_DIN  in  8  CPU write data
BUSY  out  1  copy in progress
DONE  out  1  one-cycle pulse at copy completion
ABP  out  13  picture ROM address
DP  in  16  ROM data {Z[15:12],R[11:8],G[7:4],B[3:0]}
VA  out  VA_W  video RAM address
VD  out  16  video RAM write data
VWE_AL  out  1  video RAM write strobe, active-low
VRDY  in  1  video RAM slot granted this cycle

Behaviour:
- Clock and reset: one clock CLK; MR_AL is an asynchronous, active-low reset.
- Reset (MR_AL low, async): all registers 0; FSM = IDLE; BUSY=0, DONE=0, ABP=0, VA=0, VD=0, VWE_AL=1. Reset mid-copy aborts the copy immediately, with no further writes and no DONE pulse.
- Registers: 0 SRC_L; 1 SRC_H[4:0]; 2 DST_L; 3 DST_H[5:0]; 4 WIDTH (columns = W+1); 5 HEIGHT (rows = H+1); 6 MODE: bit0 START (self-clearing), bit1 TRANSP, bits5:2 plane enable {Z,R,G,B}.
- REG_WR while BUSY=1 is ignored for all registers.
- Plane mask: a disabled plane's nibble in VD is forced to 0.
- FSM states: IDLE, FETCH, WRITE, ADV.
- IDLE -> FETCH: on a REG_WR to MODE with bit0=1. BUSY=1 from the next cycle. ABP=SRC and VA=DST are loaded on that same edge. Column and row counters are cleared.
- FETCH: hold ABP for ROM_WAIT cycles, then register masked DP into VD.
  - TRANSP=1 and masked DP==0 -> ADV (no write).
  - Otherwise -> WRITE.
- WRITE: VWE_AL=0 while in WRITE. The write completes in any cycle where VRDY=1; then -> ADV with VWE_AL=1 next cycle. If VRDY=0, stay in WRITE holding VA, VD and VWE_AL=0 indefinitely.
- ADV (1 cycle):
  - ABP = ABP+1, mod 8192.
  - If column < W: column+1, VA = VA+1 mod 2^VA_W.
  - Else: column=0, row+1, VA = row_start + DST_STRIDE mod 2^VA_W, and row_start is updated.
  - If the last pixel (column==W and row==H) was just handled: DONE=1 for one cycle, BUSY=0 on the same cycle, -> IDLE.
  - Otherwise -> FETCH.
- Throughput: each pixel takes ROM_WAIT+2 cycles when VRDY is held high; a skipped pixel takes ROM_WAIT+1.
- W=0,H=0: a single pixel is copied. W=255,H=255: 65536 pixels; counters must not overflow early.
- VA keeps its last value in IDLE; ABP keeps its last value in IDLE.

Test Plan:
- Reset: MR_AL low mid-WRITE -> VWE_AL=1, BUSY=0 asynchronously; after release, the FSM stays in IDLE and no DONE pulse occurs.
- 2x2 copy: SRC=0x0100, DST=0x0010, W=1, H=1, planes=1111, VRDY=1. Required writes: VA 0x0010, 0x0011, 0x0110, 0x0111 with VD = ROM[0x100..0x103]. DONE pulses once; BUSY is high for exactly 4*(ROM_WAIT+2) cycles.
- VRDY stall: VRDY=0 for 5 cycles during the first WRITE -> VA/VD/VWE_AL held steady; exactly one write occurs per pixel when VRDY rises.
- Transparency: TRANSP=1, ROM word at pixel 1 = 0x0000 -> no VWE_AL pulse for that pixel; VA still advances; the next pixel lands at DST+2.
- Plane mask: planes=0100 (R only), ROM=0xABCD -> VD=0x0B00.
- Wrap: SRC=0x1FFF, DST=0x3FFF, W=1, H=0 -> second pixel fetched from ABP=0x0000 and written to VA=0x0000.
- Busy lockout: write DST_L during BUSY -> the current copy is unaffected and the register read-back value is unchanged at the next start.
